// File: rtl/sum_sched_pkg.sv
// Shared types and defaults for the group-summer scheduler.
package sum_sched_pkg;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_GROUP_LEN = 128;
    localparam int unsigned DEF_TIMEOUT   = 64;
    localparam int unsigned SAMPLE_W      = 8;
    localparam int unsigned SUM_W         = 17;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Index width that stays legal for a single requester.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sum_group_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick starting after the last served lane.
module rr_arbiter
    import sum_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned ID_W    = id_width(NUM_REQ)
)(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_upd,
    input  logic [ID_W-1:0]    i_upd_idx,
    output logic [NUM_REQ-1:0] o_gnt_c,
    output logic [ID_W-1:0]    o_idx_c,
    output logic               o_any_c
);

    logic [ID_W-1:0] r_ptr;
    logic            w_found;

    // Pointer moves to the lane after the one just served.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_upd) begin
            r_ptr <= (32'(i_upd_idx) + 32'd1 >= NUM_REQ) ? '0 : i_upd_idx + ID_W'(1);
        end
    end

    always_comb begin
        o_gnt_c = '0;
        o_idx_c = '0;
        w_found = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!w_found && i_req[i] && (((32'(r_ptr) + off) % NUM_REQ) == i)) begin
                    w_found    = 1'b1;
                    o_gnt_c[i] = 1'b1;
                    o_idx_c    = ID_W'(i);
                end
            end
        end
        o_any_c = w_found;
    end

endmodule

// File: rtl/sum_group_scheduler.sv
// Shares one group summer among NUM_REQ requesters: grant, stream GROUP_LEN samples, collect result.
module sum_group_scheduler
    import sum_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter  int unsigned GROUP_LEN = DEF_GROUP_LEN,
    parameter  int unsigned TIMEOUT   = DEF_TIMEOUT,
    localparam int unsigned ID_W      = id_width(NUM_REQ)
)(
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [SAMPLE_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]          req_rd,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        s_start,
    output logic [SAMPLE_W-1:0]         s_data,
    input  logic [SUM_W-1:0]            s_sum,
    input  logic                        s_sum_valid,
    output logic [SUM_W-1:0]            res_sum,
    output logic [ID_W-1:0]             res_id,
    output logic                        res_valid,
    output logic                        res_err
);

    localparam int unsigned CNT_W = $clog2(GROUP_LEN) + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT) + 1;

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [ID_W-1:0]     r_id;
    logic                r_s_start;
    logic [CNT_W-1:0]    r_cnt;
    logic [TMO_W-1:0]    r_tmo;
    logic [SUM_W-1:0]    r_res_sum;
    logic [ID_W-1:0]     r_res_id;
    logic                r_res_valid;
    logic                r_res_err;

    logic [NUM_REQ-1:0]  w_arb_gnt;
    logic [ID_W-1:0]     w_arb_idx;
    logic                w_arb_any;
    logic [SAMPLE_W-1:0] w_lane;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_clk     (CLK),
        .i_rst_n   (RST),
        .i_req     (req),
        .i_upd     (r_state == ST_DONE),
        .i_upd_idx (r_id),
        .o_gnt_c   (w_arb_gnt),
        .o_idx_c   (w_arb_idx),
        .o_any_c   (w_arb_any)
    );

    // Sample mux keyed by the held one-hot grant.
    always_comb begin
        w_lane = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_gnt[i]) w_lane = req_data[i*SAMPLE_W +: SAMPLE_W];
        end
    end

    assign s_data    = (r_state == ST_STREAM) ? w_lane : '0;
    assign req_rd    = (r_state == ST_STREAM) ? r_gnt  : '0;
    assign gnt       = r_gnt;
    assign s_start   = r_s_start;
    assign res_sum   = r_res_sum;
    assign res_id    = r_res_id;
    assign res_valid = r_res_valid;
    assign res_err   = r_res_err;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_id        <= '0;
            r_s_start   <= 1'b0;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_res_sum   <= '0;
            r_res_id    <= '0;
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            r_s_start   <= 1'b0;
            r_res_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        r_gnt     <= w_arb_gnt;
                        r_id      <= w_arb_idx;
                        r_s_start <= 1'b1;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    r_cnt   <= '0;
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (r_cnt == CNT_W'(GROUP_LEN - 1)) begin
                        r_tmo   <= '0;
                        r_state <= ST_WAIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                // Summer result wins over a timeout landing on the same cycle.
                ST_WAIT: begin
                    if (s_sum_valid) begin
                        r_res_sum   <= s_sum;
                        r_res_err   <= 1'b0;
                        r_res_id    <= r_id;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                        r_res_sum   <= '0;
                        r_res_err   <= 1'b1;
                        r_res_id    <= r_id;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_group_scheduler.sv
// Directed bench with a stub summer and a result scoreboard for sum_group_scheduler.
module tb_sum_group_scheduler;

    localparam int unsigned GLEN = 128;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_rd;
    logic [3:0]  gnt;
    logic        s_start;
    logic [7:0]  s_data;
    logic [16:0] s_sum;
    logic        s_sum_valid;
    logic [16:0] res_sum;
    logic [1:0]  res_id;
    logic        res_valid;
    logic        res_err;

    always #5 CLK = ~CLK;

    sum_group_scheduler #(.NUM_REQ(4), .GROUP_LEN(128), .TIMEOUT(64)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req         (req),
        .req_data    (req_data),
        .req_rd      (req_rd),
        .gnt         (gnt),
        .s_start     (s_start),
        .s_data      (s_data),
        .s_sum       (s_sum),
        .s_sum_valid (s_sum_valid),
        .res_sum     (res_sum),
        .res_id      (res_id),
        .res_valid   (res_valid),
        .res_err     (res_err)
    );

    typedef struct {
        int id;
        int sum;
        int err;
        int lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   cyc = 0, n_results = 0, n_starts = 0, tx_starts = 0;
    int   n_str = 0, last_str = 0, acc = 0, cd = 0;
    int   stub_delay = 1, spur_at = 0, base = 0;
    bit   stub_en = 1'b1, armed = 1'b0, lane_inc = 1'b0;
    int   lane_base[4];
    int   lane_k[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input int sum, input int err, input int lat);
        exp_t x;
        x.id = id; x.sum = sum; x.err = err; x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic wait_results(input int target, input int budget);
        int c = 0;
        while (n_results < target && c < budget) begin
            @(posedge CLK);
            c++;
        end
        chk("result_count", 32'(n_results), 32'(target));
    endtask

    task automatic wait_starts(input int target, input int budget);
        int c = 0;
        while (n_starts < target && c < budget) begin
            @(posedge CLK);
            c++;
        end
        chk("start_count", 32'(n_starts), 32'(target));
    endtask

    task automatic check_reset_outputs();
        chk("rst_gnt",       32'(gnt),       32'd0);
        chk("rst_req_rd",    32'(req_rd),    32'd0);
        chk("rst_s_start",   32'(s_start),   32'd0);
        chk("rst_s_data",    32'(s_data),    32'd0);
        chk("rst_res_sum",   32'(res_sum),   32'd0);
        chk("rst_res_id",    32'(res_id),    32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_err",   32'(res_err),   32'd0);
    endtask

    // Monitor, stub summer and sample-supplying requesters, all on the falling edge.
    initial begin
        s_sum_valid = 1'b0;
        s_sum       = '0;
        req_data    = '0;
        for (int i = 0; i < 4; i++) begin
            lane_base[i] = 0;
            lane_k[i]    = 0;
        end
        forever begin
            @(negedge CLK);
            cyc++;
            if (RST !== 1'b1) begin
                armed     = 1'b0;
                n_str     = 0;
                tx_starts = 0;
            end else begin
                if (s_start === 1'b1) begin
                    n_starts++;
                    tx_starts++;
                    acc   = 0;
                    n_str = 0;
                    for (int i = 0; i < 4; i++) lane_k[i] = 0;
                end
                if (req_rd !== 4'b0000) begin
                    chk("rd_onehot", 32'($countones(req_rd)), 32'd1);
                    chk("rd_in_gnt", 32'(req_rd & ~gnt), 32'd0);
                    acc += int'(s_data);
                    n_str++;
                    last_str = cyc;
                    for (int i = 0; i < 4; i++) if (req_rd[i]) lane_k[i]++;
                    if (n_str == GLEN && stub_en) begin
                        armed = 1'b1;
                        cd    = stub_delay;
                    end
                end
                if (res_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_res_valid", 32'(res_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("res_id",    32'(res_id),  32'(e.id));
                        chk("res_sum",   32'(res_sum), 32'(e.sum));
                        chk("res_err",   32'(res_err), 32'(e.err));
                        chk("gnt_held",  32'(gnt),     32'(1 << e.id));
                        chk("strobes",   32'(n_str),   32'(GLEN));
                        chk("one_start", 32'(tx_starts), 32'd1);
                        chk("latency",   32'(cyc - last_str), 32'(e.lat));
                    end
                    tx_starts = 0;
                    n_results++;
                end
            end
            s_sum_valid = 1'b0;
            if (armed) begin
                if (cd == 0) begin
                    s_sum_valid = 1'b1;
                    s_sum       = 17'(acc);
                    armed       = 1'b0;
                end else begin
                    cd--;
                end
            end
            if (spur_at != 0 && n_str == spur_at && req_rd !== 4'b0000) begin
                s_sum_valid = 1'b1;
                s_sum       = 17'h1ABCD;
            end
            for (int i = 0; i < 4; i++)
                req_data[i*8 +: 8] = 8'(lane_base[i] + (lane_inc ? lane_k[i] : 0));
        end
    end

    initial begin
        RST = 1'b0;
        req = 4'b0000;
        repeat (3) @(negedge CLK);
        check_reset_outputs();
        RST = 1'b1;

        // Lane 2 alone, all ones, summer answers 10 cycles into WAIT.
        lane_base[2] = 1;
        stub_delay   = 10;
        push(2, 128, 0, 11);
        @(negedge CLK);
        req = 4'b0100;
        @(negedge CLK);
        chk("start_latency", 32'(s_start), 32'd1);
        @(negedge CLK);
        chk("start_one_cycle", 32'(s_start), 32'd0);
        chk("first_strobe", 32'(req_rd), 32'b0100);
        req = 4'b0000;
        wait_results(1, 400);

        // Fresh reset, then all four requesting: order 0,1,2,3,0 with ramp data.
        @(negedge CLK); RST = 1'b0;
        @(negedge CLK); RST = 1'b1;
        lane_inc   = 1'b1;
        stub_delay = 3;
        for (int i = 0; i < 4; i++) lane_base[i] = i * 16;
        for (int i = 0; i < 5; i++) push(i % 4, 2048 * (i % 4) + 8128, 0, 4);
        base = n_starts;
        req  = 4'b1111;
        wait_starts(base + 5, 2000);
        @(negedge CLK);
        req = 4'b0000;
        wait_results(6, 600);

        // Full-scale samples on lane 0: no truncation of the 17-bit sum.
        lane_inc     = 1'b0;
        lane_base[0] = 255;
        stub_delay   = 1;
        push(0, 32640, 0, 2);
        base = n_starts;
        @(negedge CLK);
        req = 4'b0001;
        wait_starts(base + 1, 50);
        @(negedge CLK);
        req = 4'b0000;
        wait_results(7, 400);

        // Silent summer on lane 1 times out; lane 3 is served next.
        stub_en      = 1'b0;
        lane_base[1] = 9;
        lane_base[3] = 2;
        stub_delay   = 5;
        push(1, 0, 1, 65);
        push(3, 256, 0, 6);
        base = n_starts;
        @(negedge CLK);
        req = 4'b1010;
        wait_results(8, 400);
        stub_en = 1'b1;
        wait_starts(base + 2, 50);
        @(negedge CLK);
        req = 4'b0000;
        wait_results(9, 400);

        // Stray valid during STREAM must be ignored.
        lane_base[2] = 7;
        spur_at      = 20;
        stub_delay   = 12;
        push(2, 896, 0, 13);
        base = n_starts;
        @(negedge CLK);
        req = 4'b0100;
        wait_starts(base + 1, 50);
        @(negedge CLK);
        req = 4'b0000;
        wait_results(10, 400);
        spur_at = 0;

        // Reset in the middle of a lane 3 stream; priority restarts from lane 0.
        lane_base[3] = 5;
        base = n_starts;
        @(negedge CLK);
        req = 4'b1000;
        wait_starts(base + 1, 50);
        begin
            int c = 0;
            while (n_str < 50 && c < 200) begin
                @(posedge CLK);
                c++;
            end
            chk("reached_sample_50", 32'(n_str >= 50), 32'd1);
        end
        @(negedge CLK);
        RST          = 1'b0;
        req          = 4'b1010;
        lane_base[1] = 1;
        lane_base[3] = 3;
        stub_delay   = 2;
        @(negedge CLK);
        check_reset_outputs();
        push(1, 128, 0, 3);
        push(3, 384, 0, 3);
        base = n_starts;
        RST  = 1'b1;
        wait_starts(base + 2, 400);
        @(negedge CLK);
        req = 4'b0000;
        wait_results(12, 400);

        repeat (20) @(negedge CLK);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("final_results", 32'(n_results), 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sum_group_scheduler.md
SUM_GROUP_SCHEDULER -- requirements
Module: sum_group_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one group summer.
REQ-002 Parameter GROUP_LEN, default 128, samples streamed per group.
REQ-003 Parameter TIMEOUT, default 64, max cycles waited for the summer result.
REQ-004 CLK  in  1  clock; all logic on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-low.
REQ-006 req  in  NUM_REQ  per-requester group request, level.
REQ-007 req_data  in  8*NUM_REQ  flattened sample buses; lane i = bits [8i+7:8i].
REQ-008 req_rd  out  NUM_REQ  one-hot sample-consumed strobe to the granted requester.
REQ-009 gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
REQ-010 s_start  out  1  first-data flag to the summer, one-cycle pulse.
REQ-011 s_data  out  8  sample to the summer.
REQ-012 s_sum  in  17  summer result.
REQ-013 s_sum_valid  in  1  summer result-valid pulse.
REQ-014 res_sum  out  17  captured result; res_id  out  log2(NUM_REQ)  owner; res_valid  out  1  one-cycle pulse; res_err  out  1  timeout flag, qualified by res_valid.

Function
REQ-015 FSM states IDLE, START, STREAM, WAIT, DONE; encoding in the shared package.
REQ-016 IDLE: any req bit high -> latch round-robin winner into gnt, go START; none -> stay.
REQ-017 Round robin: search starts at the lane after the last granted lane, wrapping NUM_REQ-1 -> 0; after reset, search starts at lane 0.
REQ-018 START: s_start=1 for exactly one cycle, sample counter cleared, go STREAM.
REQ-019 STREAM: s_data = req_data of granted lane (combinational mux), req_rd[granted]=1 every cycle; exactly GROUP_LEN cycles, then go WAIT.
REQ-020 Outside STREAM, s_data=0 and req_rd=0.
REQ-021 Sample counter width = clog2(GROUP_LEN)+1; terminal at GROUP_LEN-1; no wrap reachable.
REQ-022 WAIT: s_sum_valid=1 -> register s_sum into res_sum, res_err=0, go DONE; timeout counter reaching TIMEOUT-1 without valid -> res_sum=0, res_err=1, go DONE.
REQ-023 s_sum_valid in any state other than WAIT is ignored.
REQ-024 DONE: res_valid=1 one cycle, res_id=granted index, gnt cleared, round-robin pointer updated, go IDLE.
REQ-025 Deassertion of req during a transaction does not abort it; transaction completes normally.
REQ-026 Requests arriving while busy are held by the requester (level) and served later; no queueing inside the block.
REQ-027 Latency: req sampled in IDLE at edge N -> s_start high cycle N+1; samples cycles N+2..N+1+GROUP_LEN; res_valid the cycle after s_sum_valid sampled.
REQ-028 Minimum gap between transactions: one IDLE cycle.

Reset
REQ-029 RST low at a rising edge: state=IDLE, gnt=0, req_rd=0, s_start=0, s_data=0, res_sum=0, res_id=0, res_valid=0, res_err=0, counters=0, RR pointer=lane 0.
REQ-030 Reset mid-transaction aborts it silently; no res_valid issued for the aborted group.

Structure
REQ-031 Shared package sum_sched_pkg holds FSM state typedef, default GROUP_LEN/TIMEOUT/NUM_REQ constants, result width 17.
REQ-032 One sub-module, rr_arbiter (NUM_REQ-wide round-robin, one-hot out, pointer update on enable).
REQ-033 Top contains FSM, counters, data mux, result register.

Verification
REQ-034 Lane 2 only, all samples 1, stub summer returns 128 after 10 cycles -> one s_start, 128 req_rd[2] strobes, res_sum=128, res_id=2, res_err=0.
REQ-035 All four req held high -> grant order 0,1,2,3,0; each transaction exactly 128 strobes, no overlap.
REQ-036 All samples 255 on lane 0 -> res_sum=32640 (17'h07F80), no truncation.
REQ-037 Stub never asserts s_sum_valid -> res_valid after 64 WAIT cycles, res_err=1, res_sum=0, next request served.
REQ-038 RST low at sample 50 of STREAM -> all outputs reset next edge, no res_valid; new request restarts from lane 0 priority.
REQ-039 s_sum_valid pulsed during STREAM -> ignored; result taken only from the WAIT-state pulse.
